// File: rtl/udp_ts_out_sched.sv
// rtl/udp_ts_out_sched.sv - round-robin ready-frame queue feeding a one-at-a-time output dispatcher
module udp_ts_out_sched #(
  parameter int P_CHANNELS      = 4,
  parameter int P_CH_IDX_WIDTH  = 2,
  parameter int P_POINTER_WIDTH = 5,
  parameter int P_QUEUE_DEPTH   = 16,
  parameter int P_ACK_TIMEOUT   = 255
) (
  input  logic                                  payload_clk,
  input  logic                                  payload_rst,
  input  logic                                  enable,
  input  logic [P_CHANNELS-1:0]                 load_req,
  input  logic [P_CHANNELS*P_POINTER_WIDTH-1:0] load_pointer,
  output logic [P_CHANNELS-1:0]                 load_ack,
  output logic [P_CHANNELS-1:0]                 out_req,
  input  logic [P_CHANNELS-1:0]                 out_ack,
  output logic [P_POINTER_WIDTH-1:0]            out_pointer,
  output logic [P_CH_IDX_WIDTH-1:0]             out_sel,
  input  logic [P_CHANNELS-1:0]                 frame_done,
  output logic                                  busy,
  output logic [$clog2(P_QUEUE_DEPTH):0]        queue_level,
  output logic                                  timeout_err,
  output logic [15:0]                           frames_sent
);
  localparam int AW = $clog2(P_QUEUE_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_GAP} state_t;
  state_t state;

  logic [P_CH_IDX_WIDTH-1:0]  rr_ptr;
  logic                       grant_hold;
  logic [P_CH_IDX_WIDTH-1:0]  q_ch  [P_QUEUE_DEPTH];
  logic [P_POINTER_WIDTH-1:0] q_ptr [P_QUEUE_DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [7:0]                 to_cnt;

  logic                       grant_vld;
  logic [P_CH_IDX_WIDTH-1:0]  grant_idx;
  logic [P_CH_IDX_WIDTH-1:0]  cand;
  logic [P_POINTER_WIDTH-1:0] grant_ptr;
  logic                       push;
  logic                       pop;

  // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = P_CHANNELS - 1; k >= 0; k--) begin
      cand = P_CH_IDX_WIDTH'((int'(rr_ptr) + k) % P_CHANNELS);
      if (load_req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant_ptr = load_pointer[int'(grant_idx)*P_POINTER_WIDTH +: P_POINTER_WIDTH];
  end

  assign push = grant_vld && !grant_hold && (queue_level < LW'(P_QUEUE_DEPTH));
  assign pop  = (state == S_IDLE) && enable && (queue_level != '0);
  assign busy = (state != S_IDLE);

  always_ff @(posedge payload_clk) begin
    if (push) begin
      q_ch[wr_ptr]  <= grant_idx;
      q_ptr[wr_ptr] <= grant_ptr;
    end
  end

  always_ff @(posedge payload_clk) begin
    if (payload_rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_hold  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_level <= '0;
      to_cnt      <= '0;
      load_ack    <= '0;
      out_req     <= '0;
      out_sel     <= '0;
      out_pointer <= '0;
      timeout_err <= 1'b0;
      frames_sent <= '0;
    end else begin
      load_ack    <= '0;
      timeout_err <= 1'b0;
      // A request is still visible while its ack is out; skip one cycle after every grant.
      grant_hold  <= push;
      if (push) begin
        load_ack[grant_idx] <= 1'b1;
        wr_ptr              <= wr_ptr + 1'b1;
        rr_ptr              <= (grant_idx == P_CH_IDX_WIDTH'(P_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      queue_level <= queue_level + 1'b1;
      else if (pop && !push) queue_level <= queue_level - 1'b1;

      case (state)
        S_IDLE: begin
          if (pop) begin
            out_sel              <= q_ch[rd_ptr];
            out_pointer          <= q_ptr[rd_ptr];
            out_req              <= '0;
            out_req[q_ch[rd_ptr]] <= 1'b1;
            to_cnt               <= '0;
            state                <= S_REQ;
          end
        end
        S_REQ: begin
          if (out_ack[out_sel]) begin
            out_req <= '0;
            state   <= S_XFER;
          end else if (to_cnt == 8'(P_ACK_TIMEOUT - 1)) begin
            out_req     <= '0;
            timeout_err <= 1'b1;
            state       <= S_GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (frame_done[out_sel]) begin
            frames_sent <= frames_sent + 1'b1;
            state       <= S_GAP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_ts_out_sched.sv
// tb/tb_udp_ts_out_sched.sv - randomized scoreboard bench for udp_ts_out_sched
module tb_udp_ts_out_sched;
  localparam int NCH = 4;
  localparam int PW  = 5;
  localparam int QD  = 16;
  localparam int TO  = 255;

  logic              payload_clk = 1'b0;
  logic              payload_rst = 1'b1;
  logic              enable = 1'b0;
  logic [NCH-1:0]    load_req = '0;
  logic [NCH*PW-1:0] load_pointer = '0;
  logic [NCH-1:0]    load_ack;
  logic [NCH-1:0]    out_req;
  logic [NCH-1:0]    out_ack = '0;
  logic [PW-1:0]     out_pointer;
  logic [1:0]        out_sel;
  logic [NCH-1:0]    frame_done = '0;
  logic              busy;
  logic [4:0]        queue_level;
  logic              timeout_err;
  logic [15:0]       frames_sent;

  udp_ts_out_sched dut (
    .payload_clk(payload_clk), .payload_rst(payload_rst), .enable(enable),
    .load_req(load_req), .load_pointer(load_pointer), .load_ack(load_ack),
    .out_req(out_req), .out_ack(out_ack), .out_pointer(out_pointer), .out_sel(out_sel),
    .frame_done(frame_done), .busy(busy), .queue_level(queue_level),
    .timeout_err(timeout_err), .frames_sent(frames_sent)
  );

  always #5 payload_clk = ~payload_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {logic [1:0] ch; logic [PW-1:0] ptr;} entry_t;

  entry_t     m_fifo[$];
  int         m_grants[$];
  logic [1:0] m_rr = '0;
  bit         m_hold = 0;
  bit         exp_disp = 0;
  bit         idle_seen = 1;
  bit         done_edge = 0;
  int         m_frames = 0;
  longint     cyc = 0;
  int         to_seen = 0;
  int         resp_st = 0;
  bit         req_en = 0;
  bit         req_all = 0;
  bit         ack_en = 1;

  // Reference model: round-robin with a one-cycle rest after each grant, FIFO of entries.
  always @(posedge payload_clk) begin : model
    bit granted;
    logic [1:0] c;
    cyc++;
    if (payload_rst) begin
      m_fifo.delete();
      m_grants.delete();
      m_rr = '0; m_hold = 0; exp_disp = 0; m_frames = 0; done_edge = 0;
    end else begin
      granted  = 0;
      exp_disp = idle_seen && enable && (m_fifo.size() > 0);
      if (frame_done != '0) begin
        m_frames  = (m_frames + 1) % 65536;
        done_edge = 1;
      end
      if (!m_hold && m_fifo.size() < QD) begin
        for (int k = 0; k < NCH; k++) begin
          c = m_rr + 2'(k);
          if (!granted && load_req[c]) begin
            granted = 1;
            m_grants.push_back(int'(c));
            m_fifo.push_back({c, load_pointer[int'(c)*PW +: PW]});
            m_rr = c + 2'd1;
          end
        end
      end
      m_hold = granted;
    end
  end

  initial begin : monitor
    logic [NCH-1:0] prev_req;
    bit disp, prev_to, chk_idle;
    int g;
    longint disp_cyc;
    entry_t e, cur;
    prev_req = '0; prev_to = 0; chk_idle = 0; disp_cyc = 0; cur = '0;
    forever begin
      @(negedge payload_clk);
      if (load_ack != '0 || m_grants.size() != 0) begin
        if (m_grants.size() == 0) check("grant_unexpected", load_ack, 0);
        else begin
          g = m_grants.pop_front();
          check("grant", load_ack, 1 << g);
        end
      end
      disp = (out_req != '0) && (prev_req == '0);
      check("dispatch_timing", disp, exp_disp);
      if (disp) begin
        check("dispatch_has_entry", m_fifo.size() > 0, 1);
        if (m_fifo.size() > 0) begin
          e = m_fifo.pop_front();
          check("out_sel", out_sel, e.ch);
          check("out_pointer", out_pointer, e.ptr);
          check("out_req_onehot", out_req, 1 << e.ch);
          cur = e;
          disp_cyc = cyc;
        end
      end else if (busy) begin
        check("sel_stable", {out_sel, out_pointer}, {cur.ch, cur.ptr});
      end
      check("queue_level", queue_level, m_fifo.size());
      check("frames_sent", frames_sent, m_frames);
      if (chk_idle) check("gap_one_cycle", busy, 0);
      if (timeout_err) begin
        check("timeout_latency", 32'(cyc - disp_cyc), TO);
        check("timeout_width", prev_to, 0);
        to_seen++;
      end
      chk_idle  = timeout_err || done_edge;
      done_edge = 0;
      idle_seen = !busy;
      prev_req  = out_req;
      prev_to   = timeout_err;
    end
  end

  initial begin : requester
    forever begin
      @(negedge payload_clk);
      for (int c = 0; c < NCH; c++) begin
        if (load_req[c] && load_ack[c]) load_req[c] = 1'b0;
        else if (!load_req[c] && req_en && (req_all || $urandom_range(0, 2) == 0)) begin
          load_pointer[c*PW +: PW] = PW'($urandom);
          load_req[c] = 1'b1;
        end
      end
    end
  end

  initial begin : responder
    logic [1:0] ch, sp;
    int dly;
    bit acked;
    ch = '0; dly = 0; acked = 0;
    forever begin
      @(negedge payload_clk);
      out_ack = '0;
      frame_done = '0;
      if (payload_rst) resp_st = 0;
      else begin
        if (resp_st == 0 && out_req != '0) begin
          for (int i = 0; i < NCH; i++) if (out_req[i]) ch = 2'(i);
          dly = $urandom_range(0, 3); acked = 0; resp_st = 1;
        end
        if (resp_st == 1) begin
          if (out_req == '0) begin
            resp_st = acked ? 2 : 0;
            dly = $urandom_range(0, 3);
          end else if (!acked) begin
            if (ack_en && dly == 0) begin
              out_ack[ch] = 1'b1;
              acked = 1;
            end else begin
              if (dly > 0) dly--;
              if ($urandom_range(0, 3) == 0) begin
                sp = ch + 2'($urandom_range(1, 3));
                out_ack[sp] = 1'b1;
              end
            end
          end
        end
        if (resp_st == 2) begin
          if (dly == 0) begin
            frame_done[ch] = 1'b1;
            resp_st = 0;
          end else dly--;
        end
      end
    end
  end

  initial begin : main
    int guard, to_start;
    payload_rst = 1'b1;
    repeat (3) @(negedge payload_clk);
    check("rst_load_ack", load_ack, 0);
    check("rst_out_req", out_req, 0);
    check("rst_busy", busy, 0);
    check("rst_queue_level", queue_level, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_frames_sent", frames_sent, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_pointer", out_pointer, 0);
    payload_rst = 1'b0;
    enable = 1'b1;

    @(negedge payload_clk);
    load_pointer[2*PW +: PW] = 5'd7;
    load_req[2] = 1'b1;
    guard = 0;
    while (frames_sent != 16'd1 && guard < 40) begin @(negedge payload_clk); guard++; end
    check("single_frame_count", frames_sent, 1);

    req_en = 1; req_all = 1;
    repeat (40) @(negedge payload_clk);

    enable = 1'b0;
    repeat (150) @(negedge payload_clk);
    check("full_queue_level", queue_level, QD);
    enable = 1'b1;
    repeat (60) @(negedge payload_clk);
    req_all = 0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge payload_clk);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
    end
    enable = 1'b1;

    ack_en = 0;
    to_start = to_seen;
    guard = 0;
    while (to_seen < to_start + 2 && guard < 1500) begin @(negedge payload_clk); guard++; end
    check("timeouts_seen", to_seen >= to_start + 2, 1);
    ack_en = 1;
    repeat (50) @(negedge payload_clk);

    guard = 0;
    while (!(resp_st == 2 && queue_level != 0) && guard < 2000) begin @(negedge payload_clk); guard++; end
    check("xfer_reached", resp_st, 2);
    payload_rst = 1'b1;
    @(negedge payload_clk);
    check("xfer_rst_out_req", out_req, 0);
    check("xfer_rst_busy", busy, 0);
    check("xfer_rst_level", queue_level, 0);
    check("xfer_rst_frames", frames_sent, 0);
    @(negedge payload_clk);
    payload_rst = 1'b0;
    repeat (500) @(negedge payload_clk);

    req_en = 0;
    guard = 0;
    while ((queue_level != 0 || busy || load_req != '0) && guard < 3000) begin @(negedge payload_clk); guard++; end
    check("drain_level", queue_level, 0);
    check("drain_busy", busy, 0);
    check("drain_frames", frames_sent, m_frames);
    repeat (5) @(negedge payload_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
